// File: rtl/sync_event_queue.sv
// sync_event_queue
// Destination-domain event collector. Detects rising edges on an already
// synchronized pulse, timestamps each accepted edge with a free-running
// cycle counter and queues the timestamps in a small circular FIFO that a
// consumer drains through a valid/acknowledge handshake. A sticky overflow
// flag and a wrapping 16-bit total-event counter feed the status registers.
//
// The only sequencing is the FIFO occupancy itself, so there is no separate
// state machine. Every output comes straight from a register or the storage.

module sync_event_queue #(
  parameter int TIMESTAMP_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4    // power of two, at least 2
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          enable,
  input  logic                          pulseIn,
  output logic                          eventValid,
  output logic [TIMESTAMP_WIDTH-1:0]    eventTimestamp,
  input  logic                          eventAck,
  output logic [$clog2(FIFO_DEPTH):0]   eventCount,
  output logic                          overflow,
  input  logic                          clearOverflow,
  output logic [15:0]                   totalEvents
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // ------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------
  logic [TIMESTAMP_WIDTH-1:0] cycle_cnt;
  logic                       pulse_prev;
  logic [TIMESTAMP_WIDTH-1:0] storage [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count_q;
  logic                       overflow_q;
  logic [15:0]                total_q;

  // ------------------------------------------------------------------------
  // Per-cycle decisions
  // ------------------------------------------------------------------------
  logic rise_det;
  logic accepted;
  logic fifo_full;
  logic fifo_empty;
  logic do_pop;
  logic do_push;
  logic do_drop;

  // Edge detection, handshake decode and push/pop/drop arbitration.
  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch can be inferred.
  always_comb begin
    rise_det   = 1'b0;
    accepted   = 1'b0;
    fifo_full  = 1'b0;
    fifo_empty = 1'b0;
    do_pop     = 1'b0;
    do_push    = 1'b0;
    do_drop    = 1'b0;

    rise_det   = pulseIn & ~pulse_prev;
    accepted   = rise_det & enable;
    fifo_full  = (count_q == FULL_COUNT);
    fifo_empty = (count_q == '0);

    // An ack against an empty queue is simply ignored.
    do_pop     = eventAck & ~fifo_empty;

    // A full queue still takes the new entry when the head leaves in the
    // same cycle; only a truly blocked edge is dropped.
    do_push    = accepted & (~fifo_full | do_pop);
    do_drop    = accepted & fifo_full & ~do_pop;
  end

  // ------------------------------------------------------------------------
  // Sequential logic
  // ------------------------------------------------------------------------

  // Free-running timestamp source; wraps naturally and ignores enable.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + TIMESTAMP_WIDTH'(1);
    end
  end

  // Previous pulse level. Resets high so a pulse already asserted when reset
  // releases is not mistaken for a fresh edge.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pulse_prev <= 1'b1;
    end else begin
      pulse_prev <= pulseIn;
    end
  end

  // Timestamp storage; the write slot captures the counter on a push.
  // NOTE: the storage is reset on purpose so the head reads zero after
  // reset; the array is small enough that this is plain flops anyway.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (do_push) begin
      storage[wr_ptr] <= cycle_cnt;
    end
  end

  // Write pointer advances on each push and wraps modulo the depth.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer advances on each pop and wraps modulo the depth.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rd_ptr <= '0;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      overflow_q <= 1'b0;
    end else if (do_drop) begin
      overflow_q <= 1'b1;
    end else if (clearOverflow) begin
      overflow_q <= 1'b0;
    end
  end

  // Total of accepted edges, dropped ones included; wraps at 2^16.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      total_q <= '0;
    end else if (accepted) begin
      total_q <= total_q + 16'd1;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign eventValid     = ~fifo_empty;
  assign eventTimestamp = storage[rd_ptr];
  assign eventCount     = count_q;
  assign overflow       = overflow_q;
  assign totalEvents    = total_q;

endmodule

// File: tb/tb_sync_event_queue.sv
// Testbench for sync_event_queue (TIMESTAMP_WIDTH=4, FIFO_DEPTH=4).
// Inputs change on the falling edge; outputs are checked on the falling
// edge. Each stimulus cycle updates a queue of expected timestamps that is
// compared against the FIFO head on every pop and after every edge.

module tb_sync_event_queue;

  localparam int TW    = 4;
  localparam int DEPTH = 4;

  logic          clock;
  logic          resetN;
  logic          enable;
  logic          pulseIn;
  logic          eventValid;
  logic [TW-1:0] eventTimestamp;
  logic          eventAck;
  logic [2:0]    eventCount;
  logic          overflow;
  logic          clearOverflow;
  logic [15:0]   totalEvents;

  sync_event_queue #(
    .TIMESTAMP_WIDTH (TW),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clock          (clock),
    .resetN         (resetN),
    .enable         (enable),
    .pulseIn        (pulseIn),
    .eventValid     (eventValid),
    .eventTimestamp (eventTimestamp),
    .eventAck       (eventAck),
    .eventCount     (eventCount),
    .overflow       (overflow),
    .clearOverflow  (clearOverflow),
    .totalEvents    (totalEvents)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [TW-1:0] exp_q [$];
  logic [TW-1:0] cyc;        // counter value the DUT holds before the next edge
  logic          m_prev;
  logic          m_ovf;
  logic [15:0]   m_total;
  logic [15:0]   saved_total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus plus the expected-behaviour bookkeeping.
  task automatic cycle(input logic p, input logic en, input logic ack, input logic clr);
    logic rise, acc, pop, full;
    pulseIn       = p;
    enable        = en;
    eventAck      = ack;
    clearOverflow = clr;

    rise = p & ~m_prev;
    acc  = rise & en;
    full = (exp_q.size() == DEPTH);
    pop  = ack && (exp_q.size() > 0);

    if (pop) begin
      check("pop_head", eventTimestamp, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (acc) begin
      m_total++;
      if (!full || pop) exp_q.push_back(cyc);
    end
    if (acc && full && !pop) m_ovf = 1'b1;
    else if (clr)            m_ovf = 1'b0;
    m_prev = p;

    @(posedge clock);
    cyc++;
    @(negedge clock);

    check("count", eventCount, exp_q.size());
    check("valid", eventValid, exp_q.size() > 0);
    check("overflow", overflow, m_ovf);
    check("total", totalEvents, m_total);
    if (exp_q.size() > 0) check("head", eventTimestamp, exp_q[0]);
  endtask

  // Assert reset (asynchronously), verify cleared outputs, release on a
  // falling edge with the model cleared to match.
  task automatic apply_reset();
    resetN = 1'b0;
    #1;
    check("rst_valid", eventValid, 0);
    check("rst_count", eventCount, 0);
    check("rst_overflow", overflow, 0);
    check("rst_total", totalEvents, 0);
    check("rst_ts", eventTimestamp, 0);
    exp_q.delete();
    cyc     = '0;
    m_prev  = 1'b1;
    m_ovf   = 1'b0;
    m_total = '0;
    @(negedge clock);
    resetN = 1'b1;
  endtask

  initial begin
    resetN        = 1'b0;
    enable        = 1'b1;
    pulseIn       = 1'b1;
    eventAck      = 1'b0;
    clearOverflow = 1'b0;

    // Reset release with pulseIn held high: no event.
    apply_reset();
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("hold_high_total", totalEvents, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("regrow_count", eventCount, 1);
    cycle(0, 1, 1, 0);

    // Three-cycle pulse starting at counter 10: exactly one entry.
    while (cyc != 4'd10) cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("ts_at_10", eventTimestamp, 10);
    check("valid_at_10", eventValid, 1);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("one_entry", eventCount, 1);
    cycle(0, 1, 1, 0);

    // Five separated pulses without acks: four queued, one dropped.
    saved_total = m_total;
    repeat (5) begin
      cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);
    end
    check("ovf_count", eventCount, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_total", totalEvents, saved_total + 16'd5);
    repeat (4) cycle(0, 1, 1, 0);
    check("drained", eventValid, 0);
    cycle(0, 1, 0, 1);

    // Full queue, edge and ack together: count stays, no overflow.
    repeat (4) begin
      cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);
    end
    cycle(1, 1, 1, 0);
    check("full_swap_count", eventCount, 4);
    check("full_swap_ovf", overflow, 0);
    cycle(0, 1, 0, 0);

    // Drop and clear in the same cycle: set wins; clear alone then clears.
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 1);
    check("set_wins", overflow, 1);
    cycle(0, 1, 0, 1);
    check("clear_alone", overflow, 0);
    repeat (4) cycle(0, 1, 1, 0);

    // Pulses while disabled, and enable raised under a high pulse: nothing.
    saved_total = m_total;
    repeat (2) begin
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
    end
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("en0_total", totalEvents, saved_total);
    check("en0_count", eventCount, 0);

    // Counter wrap: pulses at 14 and at 0.
    while (cyc != 4'd14) cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 1, 0);
    check("wrap_ts", eventTimestamp, 0);
    cycle(0, 1, 1, 0);

    // Reset with three entries queued: outputs clear at once.
    repeat (3) begin
      cycle(1, 1, 0, 0);
      cycle(0, 1, 0, 0);
    end
    check("pre_reset_count", eventCount, 3);
    apply_reset();
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    check("post_reset_ts", eventTimestamp, 1);
    cycle(0, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
